// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response handshake bundle for the sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, out, flag_z, flag_c
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, out, flag_z, flag_c
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked ALU with single-cycle ops, bit-serial shifts and
//                a shift-add unsigned multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input wire        clk,
    input wire        rst_n,
    alu_seq_if.slave  bus
);
    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [4:0] c_OP_ADD   = 5'h00;
    localparam logic [4:0] c_OP_NOT   = 5'h01;
    localparam logic [4:0] c_OP_SHL1  = 5'h02;
    localparam logic [4:0] c_OP_ROL1  = 5'h03;
    localparam logic [4:0] c_OP_AND   = 5'h04;
    localparam logic [4:0] c_OP_XOR   = 5'h05;
    localparam logic [4:0] c_OP_OR    = 5'h06;
    localparam logic [4:0] c_OP_SUB   = 5'h07;
    localparam logic [4:0] c_OP_EQ    = 5'h08;
    localparam logic [4:0] c_OP_NE    = 5'h09;
    localparam logic [4:0] c_OP_LTU   = 5'h0A;
    localparam logic [4:0] c_OP_LTS   = 5'h0B;
    localparam logic [4:0] c_OP_SHR1  = 5'h0C;
    localparam logic [4:0] c_OP_SAR1  = 5'h0D;
    localparam logic [4:0] c_OP_RORA  = 5'h0E;
    localparam logic [4:0] c_OP_RORB  = 5'h0F;
    localparam logic [4:0] c_OP_SHL   = 5'h10;
    localparam logic [4:0] c_OP_SHR   = 5'h11;
    localparam logic [4:0] c_OP_SAR   = 5'h12;
    localparam logic [4:0] c_OP_ROR   = 5'h13;
    localparam logic [4:0] c_OP_MULLO = 5'h14;
    localparam logic [4:0] c_OP_MULHU = 5'h15;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_z;
    logic               r_c;
    logic [c_SHW:0]     r_cnt;
    logic [4:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;

    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic [c_SHW-1:0]   w_amt;
    logic               w_is_shift;
    logic               w_is_mul;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_run_res;

    // DONE frees the slot in the same cycle the consumer takes the result
    assign w_in_ready = (r_state != c_ST_RUN) && ((r_state != c_ST_DONE) || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_amt      = bus.b[c_SHW-1:0];
    assign w_is_shift = (bus.sel[4:2] == 3'b100);
    assign w_is_mul   = MUL_EN && ((bus.sel == c_OP_MULLO) || (bus.sel == c_OP_MULHU));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == c_ST_DONE);
    assign bus.out       = r_out;
    assign bus.flag_z    = r_z;
    assign bus.flag_c    = r_c;

    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        case (bus.sel)
            c_OP_ADD: begin
                w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            c_OP_NOT:             w_res = ~bus.a;
            c_OP_SHL1:            w_res = {bus.a[WIDTH-2:0], 1'b0};
            c_OP_ROL1:            w_res = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
            c_OP_AND:             w_res = bus.a & bus.b;
            c_OP_XOR:             w_res = bus.a ^ bus.b;
            c_OP_OR:              w_res = bus.a | bus.b;
            c_OP_EQ:              w_res = WIDTH'(bus.a == bus.b);
            c_OP_NE:              w_res = WIDTH'(bus.a != bus.b);
            c_OP_LTU:             w_res = WIDTH'(bus.a < bus.b);
            c_OP_LTS:             w_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            c_OP_SHR1:            w_res = {1'b0, bus.a[WIDTH-1:1]};
            c_OP_SAR1:            w_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
            c_OP_RORA, c_OP_RORB: w_res = {bus.a[0], bus.a[WIDTH-1:1]};
            // Only reached with a zero shift amount
            c_OP_SHL, c_OP_SHR, c_OP_SAR, c_OP_ROR: w_res = bus.a;
            default:              w_res = '0;
        endcase
    end

    // One iteration step; multiply holds {partial product, remaining multiplier}
    always_comb begin
        w_acc_nxt = r_acc;
        w_mul_sum = '0;
        case (r_op)
            c_OP_SHL: w_acc_nxt[WIDTH-1:0] = {r_acc[WIDTH-2:0], 1'b0};
            c_OP_SHR: w_acc_nxt[WIDTH-1:0] = {1'b0, r_acc[WIDTH-1:1]};
            c_OP_SAR: w_acc_nxt[WIDTH-1:0] = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            c_OP_ROR: w_acc_nxt[WIDTH-1:0] = {r_acc[0], r_acc[WIDTH-1:1]};
            default: begin
                w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                          + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
                w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        endcase
        w_run_res = (r_op == c_OP_MULHU) ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_out   <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == (c_SHW+1)'(1)) begin
                        r_out   <= w_run_res;
                        r_z     <= (w_run_res == '0);
                        r_c     <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_op <= bus.sel;
                        if (w_is_mul) begin
                            r_acc   <= {{WIDTH{1'b0}}, bus.b};
                            r_mcand <= bus.a;
                            r_cnt   <= (c_SHW+1)'(WIDTH);
                            r_state <= c_ST_RUN;
                        end else if (w_is_shift && (w_amt != '0)) begin
                            r_acc   <= {{WIDTH{1'b0}}, bus.a};
                            r_cnt   <= {1'b0, w_amt};
                            r_state <= c_ST_RUN;
                        end else begin
                            r_out   <= w_res;
                            r_z     <= (w_res == '0);
                            r_c     <= w_carry;
                            r_state <= c_ST_DONE;
                        end
                    end else if (bus.out_ready || (r_state != c_ST_DONE)) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq (WIDTH=16, with and without MUL).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    logic clk;
    logic rst_n;

    alu_seq_if #(.WIDTH(16)) bus  ();
    alu_seq_if #(.WIDTH(16)) bus2 ();

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) u_dut_nomul (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] res;
        logic        z;
        logic        c;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam int c_NVEC = 28;
    localparam logic [36:0] c_VEC [0:c_NVEC-1] = '{
        {5'h00, 16'hFFFF, 16'h0001}, {5'h07, 16'h0003, 16'h0005},
        {5'h07, 16'h0005, 16'h0003}, {5'h0B, 16'h8000, 16'h0001},
        {5'h0A, 16'h8000, 16'h0001}, {5'h03, 16'h8001, 16'h0000},
        {5'h01, 16'h00FF, 16'h0000}, {5'h04, 16'hF0F0, 16'h3C3C},
        {5'h06, 16'hF0F0, 16'h0F0F}, {5'h08, 16'h1234, 16'h1234},
        {5'h09, 16'h1234, 16'h1234}, {5'h0C, 16'h8002, 16'h0000},
        {5'h0D, 16'h8002, 16'h0000}, {5'h0E, 16'h0001, 16'h0000},
        {5'h0F, 16'h8001, 16'h0000}, {5'h02, 16'hC001, 16'h0000},
        {5'h12, 16'h8000, 16'h0004}, {5'h12, 16'h8000, 16'h0013},
        {5'h13, 16'h0001, 16'h0000}, {5'h10, 16'h0001, 16'h000F},
        {5'h11, 16'h8000, 16'h001F}, {5'h13, 16'h00F1, 16'h0004},
        {5'h15, 16'hFFFF, 16'hFFFF}, {5'h14, 16'hFFFF, 16'hFFFF},
        {5'h14, 16'h1234, 16'h0010}, {5'h15, 16'h1234, 16'h5678},
        {5'h17, 16'hFFFF, 16'hFFFF}, {5'h1F, 16'h1234, 16'h1234}
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference behaviour: returns {carry, result}
    function automatic logic [16:0] model(input logic [4:0] s, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        logic [31:0] p;
        int          n;
        r = '0;
        c = 1'b0;
        p = 32'(x) * 32'(y);
        n = int'(y[3:0]);
        case (s)
            5'h00: {c, r} = {1'b0, x} + {1'b0, y};
            5'h01: r = ~x;
            5'h02: r = x << 1;
            5'h03: r = {x[14:0], x[15]};
            5'h04: r = x & y;
            5'h05: r = x ^ y;
            5'h06: r = x | y;
            5'h07: {c, r} = {1'b0, x} + {1'b0, ~y} + 17'd1;
            5'h08: r = 16'(x == y);
            5'h09: r = 16'(x != y);
            5'h0A: r = 16'(x < y);
            5'h0B: r = 16'($signed(x) < $signed(y));
            5'h0C: r = x >> 1;
            5'h0D: r = 16'($signed(x) >>> 1);
            5'h0E, 5'h0F: r = {x[0], x[15:1]};
            5'h10: r = x << n;
            5'h11: r = x >> n;
            5'h12: r = 16'($signed(x) >>> n);
            5'h13: r = (x >> n) | (x << (16 - n));
            5'h14: r = p[15:0];
            5'h15: r = p[31:16];
            default: r = '0;
        endcase
        return {c, r};
    endfunction

    function automatic int lat_model(input logic [4:0] s, input logic [15:0] y);
        if (s >= 5'h10 && s <= 5'h13) return 1 + int'(y[3:0]);
        if (s == 5'h14 || s == 5'h15) return 17;
        return 1;
    endfunction

    task automatic push_exp(input logic [4:0] s, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [16:0] m;
        m     = model(s, x, y);
        e.sel = s;
        e.res = m[15:0];
        e.c   = m[16];
        e.z   = (m[15:0] == 16'h0000);
        e.lat = lat_model(s, y);
        sb.push_back(e);
    endtask

    // Called at the negedge following the acceptance edge
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check_value("busy_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic collect(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check_value("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_value($sformatf("op%02h_valid", e.sel), 32'(bus.out_valid), 32'd1);
        check_value($sformatf("op%02h_out", e.sel), 32'(bus.out), 32'(e.res));
        check_value($sformatf("op%02h_flag_z", e.sel), 32'(bus.flag_z), 32'(e.z));
        check_value($sformatf("op%02h_flag_c", e.sel), 32'(bus.flag_c), 32'(e.c));
        check_value($sformatf("op%02h_latency", e.sel), 32'(lat), 32'(e.lat));
    endtask

    task automatic do_op(input logic [4:0] s, input logic [15:0] x, input logic [15:0] y);
        int lat;
        int guard;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.sel       = s;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_value("accept_ready", 32'(bus.in_ready), 32'd1);
        push_exp(s, x, y);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        wait_valid(lat);
        collect(lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          stale;
        logic [16:0] m_add;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.sel        = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.a         = '0;
        bus2.b         = '0;
        bus2.sel       = '0;
        bus2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_out", 32'(bus.out), 32'd0);
        check_value("rst_flag_z", 32'(bus.flag_z), 32'd0);
        check_value("rst_flag_c", 32'(bus.flag_c), 32'd0);
        check_value("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < c_NVEC; i++) begin
            do_op(c_VEC[i][36:32], c_VEC[i][31:16], c_VEC[i][15:0]);
        end

        // Backpressure on an ADD result, then XOR accepted in the releasing cycle
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.sel       = 5'h00;
        bus.a         = 16'h1234;
        bus.b         = 16'h0FF1;
        bus.out_ready = 1'b0;
        push_exp(5'h00, 16'h1234, 16'h0FF1);
        m_add = model(5'h00, 16'h1234, 16'h0FF1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        collect(lat);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_value("bp_valid", 32'(bus.out_valid), 32'd1);
            check_value("bp_out", 32'(bus.out), 32'(m_add[15:0]));
            check_value("bp_flag_c", 32'(bus.flag_c), 32'(m_add[16]));
            check_value("bp_flag_z", 32'(bus.flag_z), 32'(m_add[15:0] == 16'h0));
            check_value("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.sel       = 5'h05;
        bus.a         = 16'h1234;
        bus.b         = 16'h00FF;
        #1;
        check_value("bp_same_cycle_ready", 32'(bus.in_ready), 32'd1);
        push_exp(5'h05, 16'h1234, 16'h00FF);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        collect(lat);

        // Reset in the middle of a MULHU
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel      = 5'h15;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("abort_out", 32'(bus.out), 32'd0);
        check_value("abort_flag_z", 32'(bus.flag_z), 32'd0);
        check_value("abort_flag_c", 32'(bus.flag_c), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("abort_in_ready", 32'(bus.in_ready), 32'd1);
        stale = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check_value("abort_no_result", 32'(stale), 32'd0);
        do_op(5'h00, 16'h0002, 16'h0003);

        // Multiplier absent: multiply is a single-cycle zero
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.sel      = 5'h14;
        bus2.a        = 16'hFFFF;
        bus2.b        = 16'hFFFF;
        check_value("nomul_in_ready", 32'(bus2.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check_value("nomul_valid_t1", 32'(bus2.out_valid), 32'd1);
        check_value("nomul_out", 32'(bus2.out), 32'd0);
        check_value("nomul_flag_z", 32'(bus2.flag_z), 32'd1);

        check_value("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
